// File: rtl/crcu_spu_clk_ctl_apb_if.sv
// rtl/crcu_spu_clk_ctl_apb_if.sv - APB register bus bundle for the SPU clock controller
interface crcu_spu_clk_ctl_apb_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/crcu_spu_clk_ctl_apb.sv
// rtl/crcu_spu_clk_ctl_apb.sv - APB control of the SPU clock generator with gated frequency switching
module crcu_spu_clk_ctl_apb #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic [31:0] ID_VALUE      = 32'h5350_0001
) (
    input  logic                      CRCU_CLK,
    input  logic                      CRCU_RST,
    crcu_spu_clk_ctl_apb_if.slave     apb,
    output logic [31:0]               spu_clock_ctl_reg,
    output logic                      spu_clk_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATED  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [4:0] CTL_RESET   = 5'b0_1000;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  ctl_q, ctl_d;
    logic [4:0]  pend_q, pend_d;

    logic        access, is_ctl, is_status, is_id, mapped;
    logic        ctl_wr, bad, stall, done, wr_ok;
    logic [31:0] rd_data;
    logic        unused_wdata;

    assign unused_wdata = ^apb.PWDATA[31:5];

    assign access    = apb.PSEL & apb.PENABLE;
    assign is_ctl    = (apb.PADDR == 8'h00);
    assign is_status = (apb.PADDR == 8'h04);
    assign is_id     = (apb.PADDR == 8'h08);
    assign mapped    = is_ctl | is_status | is_id;
    assign ctl_wr    = access & apb.PWRITE & is_ctl;

    // Misaligned addresses never match an exact decode, so they land in !mapped.
    assign bad   = ~mapped | (apb.PWRITE & ~is_ctl) | (apb.PWRITE & is_ctl & apb.PWDATA[2]);
    assign stall = ctl_wr & (state_q != ST_IDLE);
    assign done  = access & ~CRCU_RST & ~stall;
    assign wr_ok = done & ctl_wr & ~bad;

    always_comb begin
        rd_data = 32'h0;
        if (is_ctl)         rd_data = {27'h0, ctl_q};
        else if (is_status) rd_data = {28'h0, ctl_q[2:0], spu_clk_busy};
        else if (is_id)     rd_data = ID_VALUE;
    end

    assign apb.PREADY  = done;
    assign apb.PSLVERR = done & bad;
    assign apb.PRDATA  = (done & ~apb.PWRITE & ~bad) ? rd_data : 32'h0;

    assign spu_clock_ctl_reg = {27'h0, ctl_q};
    assign spu_clk_busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        ctl_d   = ctl_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'h0;
                if (wr_ok) begin
                    if (apb.PWDATA[2:0] == ctl_q[2:0]) begin
                        ctl_d = apb.PWDATA[4:0];
                    end else begin
                        pend_d   = apb.PWDATA[4:0];
                        ctl_d[4] = 1'b1;
                        state_d  = ST_GATED;
                    end
                end
            end
            ST_GATED: begin
                if (cnt_q == SETTLE_LAST) begin
                    ctl_d[2:0] = pend_q[2:0];
                    state_d    = ST_SETTLE;
                    cnt_d      = 8'h0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    ctl_d   = pend_q;
                    state_d = ST_IDLE;
                    cnt_d   = 8'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'h0;
            end
        endcase
    end

    always_ff @(posedge CRCU_CLK) begin
        if (CRCU_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h0;
            ctl_q   <= CTL_RESET;
            pend_q  <= 5'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: doc/crcu_spu_clk_ctl_apb.md
CRCU_SPU_CLK_CTL_APB -- requirements
Module: crcu_spu_clk_ctl_apb

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, number of CRCU_CLK cycles held gated before and after a frequency-select change (legal 1..255).
REQ-002 SHALL have parameter ID_VALUE, default 32'h5350_0001, constant returned at the ID register.
REQ-003 SHALL have port CRCU_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CRCU_RST  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL have port PSEL  input  1  APB select.
REQ-006 SHALL have port PENABLE  input  1  APB access phase.
REQ-007 SHALL have port PWRITE  input  1  APB write (1) / read (0).
REQ-008 SHALL have port PADDR  input  8  APB byte address.
REQ-009 SHALL have port PWDATA  input  32  APB write data.
REQ-010 SHALL have port PRDATA  output  32  APB read data, valid when PREADY=1 in access phase, else 0.
REQ-011 SHALL have port PREADY  output  1  APB transfer complete.
REQ-012 SHALL have port PSLVERR  output  1  APB error, valid only with PREADY=1.
REQ-013 SHALL have port spu_clock_ctl_reg  output  32  registered control word to the SPU clock generator: [2:0] freq sel (000=100MHz, 001=400MHz, 010=600MHz, 011=800MHz), [3] clk enable, [4] clk gate, [31:5] zero.
REQ-014 SHALL have port spu_clk_busy  output  1  high while a frequency-change sequence is in progress.

Function
REQ-015 SHALL treat a cycle with PSEL=1, PENABLE=1 as the access phase; all other cycles are idle/setup with PREADY=0, PSLVERR=0, PRDATA=0.
REQ-016 SHALL decode 0x00 CTL (RW), 0x04 STATUS (RO: [0]=spu_clk_busy, [3:1]=applied sel, rest 0), 0x08 ID (RO: ID_VALUE).
REQ-017 SHALL complete reads with zero wait states (PREADY=1 in the first access cycle) at every address and in every FSM state.
REQ-018 SHALL return PSLVERR=1, no state change, for: any unmapped address; write to 0x04 or 0x08; CTL write with PWDATA[2:0] in 100..111; PADDR[1:0]!=0.
REQ-019 SHALL stall a CTL write arriving while spu_clk_busy=1 (PREADY=0) until the FSM reaches IDLE, then complete it normally.
REQ-020 SHALL, on a legal CTL write with PWDATA[2:0] equal to applied sel, load spu_clock_ctl_reg[4:0]=PWDATA[4:0] at that edge, stay IDLE.
REQ-021 SHALL, on a legal CTL write with PWDATA[2:0] different from applied sel, capture PWDATA[4:0] in a pending register and run FSM IDLE->GATED->SETTLE->IDLE.
REQ-022 SHALL, on entry to GATED (write edge T), set spu_clock_ctl_reg[4]=1 keeping old [3:0]; count SETTLE_CYCLES cycles.
REQ-023 SHALL, at edge T+SETTLE_CYCLES, load [2:0]=pending sel (bit4 still 1) and enter SETTLE; count SETTLE_CYCLES cycles.
REQ-024 SHALL, at edge T+2*SETTLE_CYCLES, load [4:0]=pending value and return to IDLE.
REQ-025 SHALL drive spu_clk_busy=1 exactly while FSM is GATED or SETTLE (from T+1 through T+2*SETTLE_CYCLES inclusive-exclusive: high for 2*SETTLE_CYCLES cycles).
REQ-026 SHALL ignore PWDATA[31:5] on CTL writes; CTL reads return spu_clock_ctl_reg (including forced gate bit during a sequence).
REQ-027 SHALL use an 8-bit counter that never wraps; it clears on each state transition.

Reset
REQ-028 SHALL, while CRCU_RST=1 at a clock edge, set spu_clock_ctl_reg=32'h0000_0008 (100MHz, enabled, ungated), FSM=IDLE, counter=0, pending=0, spu_clk_busy=0.
REQ-029 SHALL abort any in-progress sequence on reset mid-operation, with reset values taking precedence over any simultaneous APB access; PREADY=0 during reset.

Verification
REQ-030 Reset then read 0x00, 0x04, 0x08 -> 32'h8, 32'h0, 32'h5350_0001, each PREADY=1 first access cycle, PSLVERR=0.
REQ-031 Write 0x00=32'h9 (sel 001) after reset -> bit4=1 at T+1, ctl=32'h19 at T+16, ctl=32'h9 at T+32, busy high 32 cycles.
REQ-032 Write 0x00=32'h18 (same sel, gate) -> ctl=32'h18 next edge, busy stays 0.
REQ-033 Write 0x00=32'hC, write 0x10, write 0x04 -> PSLVERR=1 each, ctl unchanged 32'h8.
REQ-034 During busy, second CTL write 32'hA -> PREADY=0 until busy falls, then new sequence applies; a read of 0x04 mid-sequence returns 32'h3 with PREADY=1.
REQ-035 Assert CRCU_RST at T+10 of a sequence -> ctl=32'h8, busy=0 next edge.
